modulo_decodificador_bcd_rolhas: RTL and testbench
==================================================

Name: modulo_decodificador_bcd_rolhas

Overview:
- Converts a two-digit BCD cork count (tens digit, units digit, 00..99) back into a binary count, `reg_r`.
- This is the inverse of the cork-count binary-to-BCD encoder path. It lets the display/entry side hand a BCD setpoint or count to the binary cork counter and comparator logic.
- Conversion is iterative: the tens digit is expanded by repeated +10 additions.
- Uses a start/done handshake; one conversion is in flight at a time.

Parameters:
- W_SAIDA, 7, width of the binary result `reg_r`. Must be >= 7. Upper bits beyond bit 6 are always 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- start  input  1  conversion request; sampled on the rising edge, acted on only in state OCIOSO.
- reg_rd  input  4  BCD tens digit; sampled only on the accepted start edge.
- reg_ru  input  4  BCD units digit; sampled only on the accepted start edge.
- reg_r  output  W_SAIDA  binary result; valid while done=1 and held until the next accepted start.
- busy  output  1  high in states SOMA and FIM, i.e. while a start would be ignored.
- done  output  1  one-cycle pulse in state FIM.
- erro  output  1  high together with done when either input digit is greater than 9.

Behaviour:
- Reset (asynchronous, rst=1):
  - state = OCIOSO; reg_r = 0; busy = 0; done = 0; erro = 0.
  - Internal tens counter = 0; accumulator = 0.
  - Holds for as long as rst=1. Deassertion takes effect at the next clk edge.
- States: OCIOSO, SOMA, FIM. All outputs are registered; none is a combinational path from the inputs.
- OCIOSO, start=1 at an edge:
  - If reg_rd > 9 or reg_ru > 9: go to FIM, set erro = 1, set accumulator (reg_r) = 0.
  - Else if reg_rd = 0: accumulator = reg_ru, go to FIM.
  - Else: accumulator = reg_ru, counter = reg_rd, go to SOMA.
- OCIOSO, start=0: remain in OCIOSO; reg_r and erro keep their values.
- SOMA, each edge:
  - accumulator += 10 (computed in 7 bits; overflow cannot occur because the maximum is 99); counter -= 1.
  - When the counter goes 1 -> 0 on this edge, go to FIM.
  - SOMA lasts exactly reg_rd cycles.
- FIM: done = 1 and reg_r = accumulator for exactly one cycle, then OCIOSO unconditionally.
  - busy is still 1 in FIM, so a start coincident with FIM is ignored.
- Latency: done is asserted `reg_rd + 1` cycles after the edge that accepted start.
  - Range 1 cycle (00..09) to 10 cycles (90..99). An error case takes 1 cycle.
- start while busy=1: ignored completely. It is not queued, and the inputs are not resampled.
- Input digits may change freely after the accepting edge without affecting the result.
- erro: set on acceptance of an invalid request. Cleared on the next accepted start with valid digits. Otherwise held.
- reg_r update: written only on entry to FIM; unchanged in SOMA and OCIOSO. Intermediate sums are never visible on reg_r.
- Reset mid-conversion (rst in SOMA or FIM): immediate return to reset values, with no done pulse. The next start after release behaves as a fresh conversion.
- Back-to-back operation: start held high continuously gives one conversion per (reg_rd + 2) cycles. Each start is accepted in the OCIOSO cycle that follows FIM.

Test Plan:
- Reset, then release with start=0 for 5 cycles -> reg_r = 0, busy = 0, done = 0, erro = 0 throughout. Assert rst asynchronously between clock edges -> outputs zero before the next edge.
- start with reg_rd=0, reg_ru=7 -> done pulses 1 cycle after acceptance, reg_r = 7, erro = 0, busy high for exactly 1 cycle.
- start with reg_rd=4, reg_ru=7 -> busy for 5 cycles, done on the 5th cycle after acceptance, reg_r = 47 (7'b0101111). reg_r is unchanged (still the old value) during SOMA.
- start with 9/9 -> done after 10 cycles, reg_r = 99. Then start with 0/0 -> reg_r = 0 after 1 cycle.
- Invalid input:
  - start with reg_rd=4'hA, reg_ru=3 -> done and erro = 1 after 1 cycle, reg_r = 0.
  - Next start 2/5 -> erro = 0, reg_r = 25 after 3 cycles.
- Busy and reset handling:
  - Pulse start with 6/1 while converting 8/0 -> a single done, reg_r = 80, no second conversion.
  - Assert rst on the 3rd SOMA cycle -> no done; outputs return to reset values.
  - After release, start with 1/2 -> reg_r = 12 after 2 cycles.

Source files
------------

// File: rtl/modulo_decodificador_bcd_rolhas.sv
// modulo_decodificador_bcd_rolhas: two-digit BCD cork count to binary via iterative +10 accumulation
module modulo_decodificador_bcd_rolhas #(
  parameter int W_SAIDA = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         reg_rd,
  input  logic [3:0]         reg_ru,
  output logic [W_SAIDA-1:0] reg_r,
  output logic               busy,
  output logic               done,
  output logic               erro
);
  typedef enum logic [1:0] {OCIOSO, SOMA, FIM} estado_t;
  estado_t    r_estado, w_prox;
  logic [3:0] r_cnt, w_cnt;
  logic [6:0] r_acc, w_acc;
  logic       w_inval, w_aceita;
  // next state, next counter and next accumulator; invalid digits skip straight to FIM with a zero result
  always_comb begin
    w_inval  = reg_rd > 4'd9 || reg_ru > 4'd9;
    w_aceita = r_estado == OCIOSO && start;
    w_prox   = r_estado;
    w_cnt    = r_cnt;
    w_acc    = r_acc;
    case (r_estado)
      OCIOSO: if (start) begin
        w_prox = (w_inval || reg_rd == 4'd0) ? FIM : SOMA;
        w_cnt  = w_inval ? 4'd0 : reg_rd;
        w_acc  = w_inval ? 7'd0 : {3'b000, reg_ru};
      end
      SOMA: begin
        w_prox = r_cnt == 4'd1 ? FIM : SOMA;
        w_cnt  = r_cnt - 4'd1;
        w_acc  = r_acc + 7'd10;
      end
      default: w_prox = OCIOSO;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox;
  // datapath and registered outputs; reg_r is loaded only on entry to FIM so partial sums never show
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      reg_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      erro  <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_acc <= w_acc;
      busy  <= w_prox != OCIOSO;
      done  <= w_prox == FIM;
      if (w_prox == FIM) reg_r <= W_SAIDA'(w_acc);
      if (w_aceita) erro <= w_inval;
    end
endmodule

// File: tb/tb_modulo_decodificador_bcd_rolhas.sv
// tb_modulo_decodificador_bcd_rolhas: directed checks of the BCD-to-binary cork count converter
module tb_modulo_decodificador_bcd_rolhas;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] reg_rd = 4'd0;
  logic [3:0] reg_ru = 4'd0;
  logic [6:0] reg_r;
  logic       busy, done, erro;
  int total = 0;
  int bad = 0;

  modulo_decodificador_bcd_rolhas #(.W_SAIDA(7)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_rd(reg_rd), .reg_ru(reg_ru),
    .reg_r(reg_r), .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  // one-cycle start; returns at the falling edge just after the accepting edge, then scrambles the digits
  task automatic pulse_start(input logic [3:0] rd, input logic [3:0] ru);
    @(negedge clk);
    start = 1'b1; reg_rd = rd; reg_ru = ru;
    @(negedge clk);
    start = 1'b0; reg_rd = 4'hF; reg_ru = 4'hE;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({reg_r, busy, done, erro} !== 10'd0) begin bad++; $display("FAIL reset_hold got=%h want=0", {reg_r, busy, done, erro}); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({reg_r, busy, done, erro} !== 10'd0) begin bad++; $display("FAIL reset_idle%0d got=%h want=0", i, {reg_r, busy, done, erro}); end
    end
  endtask

  // generic valid conversion: busy for rd+1 cycles, reg_r holds old value until done
  task automatic test_conv(input logic [3:0] rd, input logic [3:0] ru, input logic [6:0] exp, input logic [6:0] old);
    pulse_start(rd, ru);
    for (int i = 1; i <= int'(rd) + 1; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= int'(rd)) begin
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL conv%0d%0d_soma%0d busy=%b done=%b want busy=1 done=0", rd, ru, i, busy, done); end
        total++; if (reg_r !== old) begin bad++; $display("FAIL conv%0d%0d_hold%0d got=%0d want=%0d", rd, ru, i, reg_r, old); end
      end else begin
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL conv%0d%0d_done done=%b busy=%b want 1 1", rd, ru, done, busy); end
        total++; if (reg_r !== exp) begin bad++; $display("FAIL conv%0d%0d_result got=%0d want=%0d", rd, ru, reg_r, exp); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL conv%0d%0d_erro got=%b want=0", rd, ru, erro); end
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || reg_r !== exp) begin bad++; $display("FAIL conv%0d%0d_after busy=%b done=%b r=%0d want 0 0 %0d", rd, ru, busy, done, reg_r, exp); end
  endtask

  task automatic test_async_reset();
    pulse_start(4'd3, 4'd4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL async_pre busy=%b want=1", busy); end
    #2 rst = 1'b1;
    #1;
    total++; if ({reg_r, busy, done, erro} !== 10'd0) begin bad++; $display("FAIL async_rst got=%h want=0", {reg_r, busy, done, erro}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_invalid();
    pulse_start(4'hA, 4'd3);
    total++; if (done !== 1'b1 || erro !== 1'b1) begin bad++; $display("FAIL inval_flags done=%b erro=%b want 1 1", done, erro); end
    total++; if (reg_r !== 7'd0) begin bad++; $display("FAIL inval_result got=%0d want=0", reg_r); end
    @(negedge clk);
    total++; if (erro !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL inval_hold erro=%b done=%b want 1 0", erro, done); end
    test_conv(4'd2, 4'd5, 7'd25, 7'd0);
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    pulse_start(4'd8, 4'd0);
    if (done) dones++;
    for (int i = 2; i <= 20; i++) begin
      if (i == 3) begin start = 1'b1; reg_rd = 4'd6; reg_ru = 4'd1; end
      if (i == 4) start = 1'b0;
      if (i == 9) begin start = 1'b1; reg_rd = 4'd6; reg_ru = 4'd1; end
      if (i == 10) start = 1'b0;
      @(negedge clk);
      if (done) dones++;
      if (i == 9) begin
        total++; if (done !== 1'b1 || reg_r !== 7'd80) begin bad++; $display("FAIL busy_done done=%b r=%0d want 1 80", done, reg_r); end
      end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL busy_count got=%0d want=1", dones); end
    total++; if (reg_r !== 7'd80 || busy !== 1'b0) begin bad++; $display("FAIL busy_final r=%0d busy=%b want 80 0", reg_r, busy); end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    pulse_start(4'd5, 4'd5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({reg_r, busy, done, erro} !== 10'd0) begin bad++; $display("FAIL midrst got=%h want=0", {reg_r, busy, done, erro}); end
    repeat (3) begin @(negedge clk); if (done) dones++; end
    rst = 1'b0;
    repeat (8) begin @(negedge clk); if (done) dones++; end
    total++; if (dones !== 0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_nodone dones=%0d busy=%b want 0 0", dones, busy); end
    test_conv(4'd1, 4'd2, 7'd12, 7'd0);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; reg_rd = 4'd1; reg_ru = 4'd3;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (done) dones++;
      total++; if (done !== (i % 3 == 2)) begin bad++; $display("FAIL b2b_done%0d got=%b want=%b", i, done, i % 3 == 2); end
    end
    start = 1'b0;
    total++; if (dones !== 3 || reg_r !== 7'd13) begin bad++; $display("FAIL b2b_total dones=%0d r=%0d want 3 13", dones, reg_r); end
  endtask

  initial begin
    test_reset();
    test_conv(4'd0, 4'd7, 7'd7, 7'd0);
    test_async_reset();
    test_conv(4'd0, 4'd7, 7'd7, 7'd0);
    test_conv(4'd4, 4'd7, 7'd47, 7'd7);
    test_conv(4'd9, 4'd9, 7'd99, 7'd47);
    test_conv(4'd0, 4'd0, 7'd0, 7'd99);
    test_invalid();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
